// File: rtl/spi_sb_master_pkg.sv
// Shared definitions for the SB_SPI system-bus master: register offsets,
// status bit positions and the sequencing FSM state type.
// Optional build macro: SPI_SB_MASTER_TIMEOUT_EN (ack watchdog).
package spi_sb_pkg;

  // Low-nibble register offsets inside the SB_SPI block
  localparam logic [3:0] REG_CR1  = 4'h9;
  localparam logic [3:0] REG_CR2  = 4'hA;
  localparam logic [3:0] REG_BR   = 4'hB;
  localparam logic [3:0] REG_SR   = 4'hC;
  localparam logic [3:0] REG_TXDR = 4'hD;
  localparam logic [3:0] REG_RXDR = 4'hE;
  localparam logic [3:0] REG_CSR  = 4'hF;

  // SPISR bit positions
  localparam int SR_TRDY = 4;
  localparam int SR_RRDY = 3;

  // CR1 value that enables the SPI core
  localparam logic [7:0] CR1_ENABLE = 8'h80;

  typedef enum logic [3:0] {
    ST_INIT_CR1 = 4'd0,
    ST_INIT_CR2 = 4'd1,
    ST_INIT_BR  = 4'd2,
    ST_IDLE     = 4'd3,
    ST_CS_ON    = 4'd4,
    ST_POLL_T   = 4'd5,
    ST_WR_TX    = 4'd6,
    ST_POLL_R   = 4'd7,
    ST_RD_RX    = 4'd8,
    ST_CS_OFF   = 4'd9
  } state_t;

endpackage

// File: rtl/spi_sb_master_if.sv
// Stream and system-bus signal bundle for spi_sb_master.
// master modport: the spi_sb_master side; slave modport: the producer/SB_SPI side.
interface spi_sb_master_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sb_stb;
  logic       sb_rw;
  logic [7:0] sb_adr;
  logic [7:0] sb_dat_o;
  logic [7:0] sb_dat_i;
  logic       sb_ack;

  modport master (
    input  tx_data, tx_last, tx_valid, sb_dat_i, sb_ack,
    output tx_ready, rx_data, rx_valid, busy, sb_stb, sb_rw, sb_adr, sb_dat_o
  );

  modport slave (
    output tx_data, tx_last, tx_valid, sb_dat_i, sb_ack,
    input  tx_ready, rx_data, rx_valid, busy, sb_stb, sb_rw, sb_adr, sb_dat_o
  );
endinterface

// File: rtl/spi_sb_master_xact.sv
// sb_bus_xact: one SB_SPI system-bus transaction per start request.
// Holds strobe/rw/address/data stable until ack, captures read data on the
// ack cycle and reports completion one cycle later.
// Optional build macro: SPI_SB_MASTER_TIMEOUT_EN adds an ack watchdog (tmo).
module sb_bus_xact #(
  parameter logic [7:0] RESET_ADR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] adr,
  input  logic [7:0] wdat,
  output logic       done,
  output logic [7:0] rdat,
`ifdef SPI_SB_MASTER_TIMEOUT_EN
  output logic       tmo,
`endif
  output logic       sb_stb,
  output logic       sb_rw,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dat_o,
  input  logic [7:0] sb_dat_i,
  input  logic       sb_ack
);

`ifdef SPI_SB_MASTER_TIMEOUT_EN
  // Strobe cycle 65535 is the last one allowed to see an ack
  localparam logic [15:0] WD_LIMIT = 16'hFFFE;
  logic [15:0] wd_cnt;
`endif

  // Launch a transaction when idle, hold it until ack, then drop strobe and flag done
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_stb   <= 1'b0;
      sb_rw    <= 1'b0;
      sb_adr   <= RESET_ADR;
      sb_dat_o <= 8'h00;
      done     <= 1'b0;
      rdat     <= 8'h00;
`ifdef SPI_SB_MASTER_TIMEOUT_EN
      tmo      <= 1'b0;
      wd_cnt   <= 16'd0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SPI_SB_MASTER_TIMEOUT_EN
      tmo  <= 1'b0;
`endif
      if (sb_stb) begin
        if (sb_ack) begin
          sb_stb <= 1'b0;
          done   <= 1'b1;
          if (!sb_rw) rdat <= sb_dat_i;
        end
`ifdef SPI_SB_MASTER_TIMEOUT_EN
        else if (wd_cnt == WD_LIMIT) begin
          sb_stb <= 1'b0;
          tmo    <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 16'd1;
        end
`endif
      end else if (start) begin
        sb_stb   <= 1'b1;
        sb_rw    <= rw;
        sb_adr   <= adr;
        sb_dat_o <= wdat;
`ifdef SPI_SB_MASTER_TIMEOUT_EN
        wd_cnt   <= 16'd0;
`endif
      end
    end
  end

endmodule

// File: rtl/spi_sb_master.sv
// spi_sb_master: configures an iCE40 SB_SPI hard block after reset, then
// runs one full-duplex byte per accepted tx stream beat, managing chip select
// around tx_last-delimited bursts and returning each received byte on rx_*.
// Optional build macro: SPI_SB_MASTER_TIMEOUT_EN (sticky timeout output).
module spi_sb_master
  import spi_sb_pkg::*;
#(
  parameter logic [3:0] BUS_ADDR74 = 4'b0000,
  parameter logic [7:0] CLK_DIV    = 8'd3,
  parameter logic [3:0] CS_MASK    = 4'b0001,
  parameter logic [7:0] CR2_VAL    = 8'hC0
) (
  input  logic              clk,
  input  logic              reset,
  spi_sb_master_if.master   bus
`ifdef SPI_SB_MASTER_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  state_t     state, state_nxt;
  logic       x_start, x_req, x_rw, x_done;
  logic [3:0] x_off;
  logic [7:0] x_wdat, x_rdat;
  logic       stb_w, rw_w;
  logic [7:0] adr_w, dat_w;
  logic       tmo;
  logic [7:0] tx_byte;
  logic       tx_last_q;
  logic       cs_on;

  sb_bus_xact #(
    .RESET_ADR ({BUS_ADDR74, 4'h0})
  ) u_xact (
    .clk      (clk),
    .reset    (reset),
    .start    (x_start),
    .rw       (x_rw),
    .adr      ({BUS_ADDR74, x_off}),
    .wdat     (x_wdat),
    .done     (x_done),
    .rdat     (x_rdat),
`ifdef SPI_SB_MASTER_TIMEOUT_EN
    .tmo      (tmo),
`endif
    .sb_stb   (stb_w),
    .sb_rw    (rw_w),
    .sb_adr   (adr_w),
    .sb_dat_o (dat_w),
    .sb_dat_i (bus.sb_dat_i),
    .sb_ack   (bus.sb_ack)
  );

`ifndef SPI_SB_MASTER_TIMEOUT_EN
  assign tmo = 1'b0;
`endif

  assign bus.sb_stb   = stb_w;
  assign bus.sb_rw    = rw_w;
  assign bus.sb_adr   = adr_w;
  assign bus.sb_dat_o = dat_w;
  assign bus.tx_ready = (state == ST_IDLE);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.rx_valid = (state == ST_RD_RX) && x_done;
  assign bus.rx_data  = x_rdat;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT_CR1;
    else       state <= state_nxt;
  end

  // Next-state: advance on transaction completion, a watchdog expiry returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT_CR1: if (x_done) state_nxt = ST_INIT_CR2;
      ST_INIT_CR2: if (x_done) state_nxt = ST_INIT_BR;
      ST_INIT_BR:  if (x_done) state_nxt = ST_IDLE;
      ST_IDLE:     if (bus.tx_valid) state_nxt = cs_on ? ST_POLL_T : ST_CS_ON;
      ST_CS_ON:    if (x_done) state_nxt = ST_POLL_T;
      ST_POLL_T:   if (x_done) state_nxt = x_rdat[SR_TRDY] ? ST_WR_TX : ST_POLL_T;
      ST_WR_TX:    if (x_done) state_nxt = ST_POLL_R;
      ST_POLL_R:   if (x_done) state_nxt = x_rdat[SR_RRDY] ? ST_RD_RX : ST_POLL_R;
      ST_RD_RX:    if (x_done) state_nxt = tx_last_q ? ST_CS_OFF : ST_IDLE;
      ST_CS_OFF:   if (x_done) state_nxt = ST_IDLE;
      default:     state_nxt = ST_INIT_CR1;
    endcase
    if (tmo) state_nxt = ST_IDLE;
  end

  // Output decode: the bus transaction each state issues; a new strobe only
  // after the previous one has finished and its done cycle has been consumed
  always_comb begin
    x_req  = 1'b0;
    x_rw   = 1'b0;
    x_off  = REG_CR1;
    x_wdat = 8'h00;
    case (state)
      ST_INIT_CR1: begin x_req = 1'b1; x_rw = 1'b1; x_off = REG_CR1;  x_wdat = CR1_ENABLE;      end
      ST_INIT_CR2: begin x_req = 1'b1; x_rw = 1'b1; x_off = REG_CR2;  x_wdat = CR2_VAL;         end
      ST_INIT_BR:  begin x_req = 1'b1; x_rw = 1'b1; x_off = REG_BR;   x_wdat = CLK_DIV;         end
      ST_CS_ON:    begin x_req = 1'b1; x_rw = 1'b1; x_off = REG_CSR;  x_wdat = {4'h0, CS_MASK}; end
      ST_POLL_T:   begin x_req = 1'b1; x_rw = 1'b0; x_off = REG_SR;                             end
      ST_WR_TX:    begin x_req = 1'b1; x_rw = 1'b1; x_off = REG_TXDR; x_wdat = tx_byte;         end
      ST_POLL_R:   begin x_req = 1'b1; x_rw = 1'b0; x_off = REG_SR;                             end
      ST_RD_RX:    begin x_req = 1'b1; x_rw = 1'b0; x_off = REG_RXDR;                           end
      ST_CS_OFF:   begin x_req = 1'b1; x_rw = 1'b1; x_off = REG_CSR;  x_wdat = 8'h00;           end
      default:     x_req = 1'b0;
    endcase
    x_start = x_req && !stb_w && !x_done && !tmo;
  end

  // Byte latch on handshake and chip-select tracking across a burst
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_on <= 1'b0;
    end else begin
      if ((state == ST_CS_ON) && x_done)  cs_on <= 1'b1;
      if ((state == ST_CS_OFF) && x_done) cs_on <= 1'b0;
      if (tmo)                            cs_on <= 1'b0;
    end
    if ((state == ST_IDLE) && bus.tx_valid) begin
      tx_byte   <= bus.tx_data;
      tx_last_q <= bus.tx_last;
    end
  end

`ifdef SPI_SB_MASTER_TIMEOUT_EN
  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)    timeout <= 1'b0;
    else if (tmo) timeout <= 1'b1;
  end
`endif

endmodule

// File: doc/spi_sb_master.md
Name: spi_sb_master

Overview:
- System-bus initiator for the iCE40 hard SPI primitive (SB_SPI).
- Drives strobe, read/write, address and write data onto the primitive's bus, and consumes its ack and read data.
- Configures the primitive after reset, then runs full-duplex byte transfers from a valid/ready stream.
- Sits between the step-generator/command logic and the SB_SPI instance; returns each received byte on a valid-only output.

Parameters:
- BUS_ADDR74, 4'b0000, upper address nibble of the target SB_SPI (must match the instance's BUS_ADDR74).
- CLK_DIV, 8'd3, value written to SPIBR (SPI clock divider).
- CS_MASK, 4'b0001, value written to SPICSR to select a device.
- CR2_VAL, 8'hC0, value written to SPICR2 (master mode, CS hold).

Ports:
- clk  in  1  system clock, same clock as SB_SPI SBCLKI
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte to shift out
- tx_last  in  1  release CS after this byte
- tx_valid  in  1  tx_data/tx_last valid
- tx_ready  out  1  byte accepted when tx_valid && tx_ready
- rx_data  out  8  byte shifted in
- rx_valid  out  1  one-cycle pulse, rx_data valid
- busy  out  1  high when not in IDLE
- sb_stb  out  1  bus strobe (to SBSTBI)
- sb_rw  out  1  1 = write (to SBRWI)
- sb_adr  out  8  {BUS_ADDR74, reg offset} (to SBADRI7..0)
- sb_dat_o  out  8  write data (to SBDATI7..0)
- sb_dat_i  in  8  read data (from SBDATO7..0)
- sb_ack  in  1  transaction ack (from SBACKO)

Behaviour:
- Register offsets, low nibble: CR1=9, CR2=A, BR=B, SR=C, TXDR=D, RXDR=E, CSR=F.
- SR bits: TRDY=bit4, RRDY=bit3.
- Reset values: all outputs 0, except sb_adr={BUS_ADDR74,4'h0}. FSM goes to INIT_CR1.
- Bus cycle:
  - sb_stb, sb_rw, sb_adr and sb_dat_o rise together and stay stable until the cycle sb_ack=1 is sampled.
  - sb_stb drops the next cycle; it is low for at least 1 cycle between transactions.
  - Read data is captured from sb_dat_i on the ack cycle.
  - An ack while sb_stb=0 is ignored.
- FSM states and transitions:
  - INIT_CR1: write 8'h80. -> INIT_CR2
  - INIT_CR2: write CR2_VAL. -> INIT_BR
  - INIT_BR: write CLK_DIV. -> IDLE
  - IDLE: tx_ready=1. On handshake, latch byte and last flag. If CS not asserted -> CS_ON, else -> POLL_T.
  - CS_ON: write CS_MASK to CSR. -> POLL_T
  - POLL_T: read SR. TRDY=1 -> WR_TX, else repeat.
  - WR_TX: write latched byte to TXDR. -> POLL_R
  - POLL_R: read SR. RRDY=1 -> RD_RX, else repeat.
  - RD_RX: read RXDR; rx_valid pulses with rx_data in the cycle after ack. last=1 -> CS_OFF, else -> IDLE.
  - CS_OFF: write 8'h00 to CSR. -> IDLE
- tx_ready is high only in IDLE. Exactly one byte is in flight.
- tx_ready is combinationally independent of tx_valid.
- busy = (state != IDLE).
- Reset mid-transaction: sb_stb drops the next cycle; configuration re-runs from INIT_CR1; the internal CS flag clears; no rx_valid.
- tx_valid during init is held off (tx_ready=0).

Optional Feature:
- Macro: SPI_SB_MASTER_TIMEOUT_EN.
- Defined:
  - Adds a 16-bit ack watchdog and output port `timeout` (out, 1, sticky, cleared only by reset).
  - If sb_stb stays high 65535 cycles without ack: set timeout, drop sb_stb, go to IDLE with CS flag cleared, no rx_valid.
- Undefined: no port, no counter; waits for ack indefinitely.

Decomposition:
- Package spi_sb_pkg holds:
  - Register-offset localparams.
  - SR bit indices.
  - The FSM state enum typedef.
- One sub-module, sb_bus_xact, owns the strobe/ack handshake and the read-data capture.
  - Inputs: start, rw, adr, wdat.
  - Outputs: done, rdat.
  - The FSM sequences it.

Test Plan:
- Reset, then a bus model acking each strobe after 2 cycles -> writes exactly (adr 09,80), (0A,C0), (0B,03) in order, then tx_ready=1.
- Send tx_data=A5 with tx_last=1; SR model returns 00 once, then 10; then 08; RXDR=3C -> order CSF←01, SR rd×2, TXDR←A5, SR rd, RXDR rd, CSF←00; rx_data=3C with rx_valid for one cycle.
- Send two bytes 11 (last=0) then 22 (last=1) -> single CSF←01 before the first byte, single CSF←00 after the second; two rx_valid pulses.
- Ack held low 5 cycles -> sb_stb, sb_adr and sb_dat_o stable the whole time; sb_stb low for at least 1 cycle afterwards.
- Assert reset while POLL_R strobe is pending -> sb_stb=0 the next cycle; init sequence restarts at adr 09; no rx_valid.
- (SPI_SB_MASTER_TIMEOUT_EN) Never ack -> timeout=1 at strobe cycle 65535, sb_stb=0, tx_ready=1 afterwards.
